// File: rtl/alu_op_sequencer_if.sv
// ---------------------------------------------------------------------------
// alu_op_sequencer_if
// Bundles the three buses of the ALU operation sequencer into one interface:
//   command bus : cmd_valid, cmd_ready, cmd_op[3:0], cmd_a[15:0], cmd_b[15:0], cmd_c
//   result bus  : res_valid, res_ready, res_data[15:0], res_zer, res_neg
//   ALU bus     : alu_m[15:0], alu_n[15:0], alu_c, alu_opc[2:0] (to the ALU)
//                 alu_f[15:0], alu_zer, alu_neg (from the ALU)
// modport slave  : the sequencer itself.
// modport master : its environment. This is the command issuer, the result
//                  consumer and the combinational ALU.
// ---------------------------------------------------------------------------
interface alu_op_sequencer_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [3:0]  cmd_op;
   logic [15:0] cmd_a;
   logic [15:0] cmd_b;
   logic        cmd_c;

   logic        res_valid;
   logic        res_ready;
   logic [15:0] res_data;
   logic        res_zer;
   logic        res_neg;

   logic [15:0] alu_m;
   logic [15:0] alu_n;
   logic        alu_c;
   logic [2:0]  alu_opc;
   logic [15:0] alu_f;
   logic        alu_zer;
   logic        alu_neg;

   modport slave (
      input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_c, res_ready, alu_f, alu_zer, alu_neg,
      output cmd_ready, res_valid, res_data, res_zer, res_neg, alu_m, alu_n, alu_c, alu_opc
   );

   modport master (
      output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_c, res_ready, alu_f, alu_zer, alu_neg,
      input  cmd_ready, res_valid, res_data, res_zer, res_neg, alu_m, alu_n, alu_c, alu_opc
   );
endinterface

// File: rtl/alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// alu_op_sequencer
// This module drives a 16-bit combinational ALU. It accepts one macro-operation
// at a time and runs it as a sequence of ALU steps, one step per cycle. It then
// holds the final result until the consumer takes it.
// Supported macro-operations:
//   RAW : one native ALU operation
//   SUB : a - b
//   NEG : -a
//   ABS : |a|
//   MUL : a * b, low 16 bits
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset; it aborts any operation in progress
//   bus : alu_op_sequencer_if.slave, carrying the command, result and ALU buses
// ---------------------------------------------------------------------------
module alu_op_sequencer (
   input  logic               clk,
   input  logic               rst,
   alu_op_sequencer_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t      state;
   state_t      state_next;

   logic [3:0]  op_q;
   logic [15:0] a_q;
   logic [15:0] b_q;
   logic        c_q;
   logic [15:0] t_q;
   logic [15:0] acc_q;
   logic [15:0] x_q;
   logic [15:0] y_q;
   logic [1:0]  step_q;
   logic [3:0]  iter_q;

   logic [15:0] res_data_q;
   logic        res_zer_q;
   logic        res_neg_q;

   logic        accept;
   logic        reserved_cmd;
   logic        last_step;
   logic        capture;

   assign bus.cmd_ready = (state == IDLE) && !rst;
   assign bus.res_valid = (state == DONE);
   assign bus.res_data  = res_data_q;
   assign bus.res_zer   = res_zer_q;
   assign bus.res_neg   = res_neg_q;

   assign accept       = bus.cmd_valid && bus.cmd_ready;
   assign reserved_cmd = (bus.cmd_op[3:2] == 2'b11);

   // State register. Reset from any state returns to IDLE, so an operation
   // that is running or waiting in DONE is dropped without producing a result.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic and ALU drive. While RUN is active, op_q and step_q
   // select the ALU step. last_step marks the final step of the operation.
   // capture marks a step whose ALU output and flags become the result.
   // For MUL, capture is the A step, because the final product (and its
   // flags) comes from the 16th A step. The trailing B and C steps do not
   // touch the accumulator.
   always_comb begin
      state_next  = state;
      bus.alu_m   = 16'h0000;
      bus.alu_n   = 16'h0000;
      bus.alu_c   = 1'b0;
      bus.alu_opc = 3'b100;
      last_step   = 1'b0;
      capture     = 1'b0;

      case (state)
         IDLE: begin
            if (accept) begin
               state_next = reserved_cmd ? DONE : RUN;
            end
         end

         RUN: begin
            if (!op_q[3]) begin
               bus.alu_m   = a_q;
               bus.alu_n   = b_q;
               bus.alu_c   = c_q;
               bus.alu_opc = op_q[2:0];
               last_step   = 1'b1;
               capture     = 1'b1;
            end else begin
               case (op_q[1:0])
                  2'b00: begin
                     if (step_q == 2'd0) begin
                        bus.alu_m   = b_q;
                        bus.alu_opc = 3'b110;
                     end else begin
                        bus.alu_m   = a_q;
                        bus.alu_n   = t_q;
                        bus.alu_c   = 1'b1;
                        bus.alu_opc = 3'b000;
                        last_step   = 1'b1;
                        capture     = 1'b1;
                     end
                  end
                  2'b01: begin
                     if (step_q == 2'd0) begin
                        bus.alu_m   = a_q;
                        bus.alu_opc = 3'b110;
                     end else begin
                        bus.alu_m   = t_q;
                        bus.alu_opc = 3'b010;
                        last_step   = 1'b1;
                        capture     = 1'b1;
                     end
                  end
                  2'b10: begin
                     if (step_q == 2'd0) begin
                        bus.alu_m   = a_q;
                        bus.alu_opc = 3'b000;
                        if (!bus.alu_neg) begin
                           last_step = 1'b1;
                           capture   = 1'b1;
                        end
                     end else if (step_q == 2'd1) begin
                        bus.alu_m   = a_q;
                        bus.alu_opc = 3'b110;
                     end else begin
                        bus.alu_m   = t_q;
                        bus.alu_opc = 3'b010;
                        last_step   = 1'b1;
                        capture     = 1'b1;
                     end
                  end
                  default: begin
                     if (step_q == 2'd0) begin
                        bus.alu_m   = acc_q;
                        bus.alu_n   = y_q[0] ? x_q : 16'h0000;
                        bus.alu_opc = 3'b000;
                        capture     = 1'b1;
                     end else if (step_q == 2'd1) begin
                        bus.alu_m   = x_q;
                        bus.alu_n   = x_q;
                        bus.alu_opc = 3'b000;
                     end else begin
                        bus.alu_n   = y_q;
                        bus.alu_opc = 3'b001;
                        last_step   = (iter_q == 4'd15);
                     end
                  end
               endcase
            end
            if (last_step) begin
               state_next = DONE;
            end
         end

         DONE: begin
            if (bus.res_ready) begin
               state_next = IDLE;
            end
         end

         default: state_next = IDLE;
      endcase
   end

   // Operand, scratch and result registers. The command is latched on accept.
   // A reserved opcode writes its fixed result at once, so it runs no steps.
   // During RUN, each ALU output goes back into the register that the current
   // step updates.
   always_ff @(posedge clk) begin
      if (rst) begin
         op_q       <= 4'h0;
         a_q        <= 16'h0000;
         b_q        <= 16'h0000;
         c_q        <= 1'b0;
         t_q        <= 16'h0000;
         acc_q      <= 16'h0000;
         x_q        <= 16'h0000;
         y_q        <= 16'h0000;
         step_q     <= 2'd0;
         iter_q     <= 4'd0;
         res_data_q <= 16'h0000;
         res_zer_q  <= 1'b0;
         res_neg_q  <= 1'b0;
      end else if (accept) begin
         op_q   <= bus.cmd_op;
         a_q    <= bus.cmd_a;
         b_q    <= bus.cmd_b;
         c_q    <= bus.cmd_c;
         t_q    <= 16'h0000;
         acc_q  <= 16'h0000;
         x_q    <= bus.cmd_a;
         y_q    <= bus.cmd_b;
         step_q <= 2'd0;
         iter_q <= 4'd0;
         if (reserved_cmd) begin
            res_data_q <= 16'h0000;
            res_zer_q  <= 1'b1;
            res_neg_q  <= 1'b0;
         end
      end else if (state == RUN) begin
         if (capture) begin
            res_data_q <= bus.alu_f;
            res_zer_q  <= bus.alu_zer;
            res_neg_q  <= bus.alu_neg;
         end
         if (op_q[3] && (op_q[1:0] == 2'b11)) begin
            case (step_q)
               2'd0:    acc_q <= bus.alu_f;
               2'd1:    x_q   <= bus.alu_f;
               default: y_q   <= bus.alu_f;
            endcase
            if (step_q == 2'd2) begin
               step_q <= 2'd0;
               iter_q <= iter_q + 4'd1;
            end else begin
               step_q <= step_q + 2'd1;
            end
         end else begin
            t_q    <= bus.alu_f;
            step_q <= step_q + 2'd1;
         end
      end
   end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_op_sequencer
// Self-checking bench for alu_op_sequencer. It supplies the combinational ALU.
// It computes each expected result, its flags and its latency directly from
// the arithmetic meaning of each macro-operation.
// ---------------------------------------------------------------------------
module tb_alu_op_sequencer;

   logic clk;
   logic rst;
   int   num_vectors;
   int   num_miscompares;

   alu_op_sequencer_if bus ();

   alu_op_sequencer dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running clock with a 10-unit period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Behaviour of the 16-bit ALU for one opcode.
   function automatic logic [15:0] aluFunc(input logic [2:0] opc, input logic [15:0] m,
                                           input logic [15:0] n, input logic c);
      logic signed [15:0] sm;
      logic signed [15:0] sn;
      logic [15:0]        half_m;
      logic [15:0]        half_n;
      logic [15:0]        r;
      sm     = m;
      sn     = n;
      half_m = sm >>> 1;
      half_n = sn >>> 1;
      case (opc)
         3'b000:  r = m + n + {15'd0, c};
         3'b001:  r = m + half_n;
         3'b010:  r = m + 16'd1;
         3'b100:  r = m & n;
         3'b101:  r = m | n;
         3'b110:  r = ~m;
         default: r = m + half_m;
      endcase
      return r;
   endfunction

   // The combinational ALU that the sequencer drives.
   always_comb begin
      bus.alu_f   = aluFunc(bus.alu_opc, bus.alu_m, bus.alu_n, bus.alu_c);
      bus.alu_zer = (bus.alu_f == 16'h0000);
      bus.alu_neg = bus.alu_f[15];
   end

   // Expected result of a macro-operation, computed arithmetically.
   function automatic logic [15:0] refResult(input logic [3:0] op, input logic [15:0] a,
                                             input logic [15:0] b, input logic c);
      logic [15:0] r;
      logic [31:0] prod;
      if (!op[3]) begin
         r = aluFunc(op[2:0], a, b, c);
      end else begin
         case (op[2:0])
            3'b000:  r = a - b;
            3'b001:  r = 16'h0000 - a;
            3'b010:  r = a[15] ? (16'h0000 - a) : a;
            3'b011: begin
               prod = {16'h0000, a} * {16'h0000, b};
               r    = prod[15:0];
            end
            default: r = 16'h0000;
         endcase
      end
      return r;
   endfunction

   // Expected number of cycles from the accept edge to res_valid.
   function automatic int refLatency(input logic [3:0] op, input logic [15:0] a);
      int lat;
      if (!op[3]) begin
         lat = 2;
      end else begin
         case (op[2:0])
            3'b000, 3'b001: lat = 3;
            3'b010:         lat = a[15] ? 4 : 2;
            3'b011:         lat = 49;
            default:        lat = 1;
         endcase
      end
      return lat;
   endfunction

   // One comparison: count it and report a mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      num_vectors++;
      if (observed !== expected) begin
         num_miscompares++;
         $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // Runs one command and checks its latency, result and flags. The result is
   // then held for 'hold' cycles while stray cmd_valid pulses are driven,
   // after which the result is accepted.
   task automatic applyStimulus(input logic [3:0] op, input logic [15:0] a,
                                input logic [15:0] b, input logic c, input int hold);
      logic [15:0] exp_data;
      int          exp_lat;
      int          lat;
      int          wait_cnt;
      exp_data = refResult(op, a, b, c);
      exp_lat  = refLatency(op, a);

      wait_cnt = 0;
      while (!bus.cmd_ready && wait_cnt < 100) begin
         @(posedge clk);
         #1;
         wait_cnt++;
      end
      checkOutput("cmd_ready_idle", {31'd0, bus.cmd_ready}, 32'd1);
      checkOutput("alu_opc_idle", {29'd0, bus.alu_opc}, 32'd4);

      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      bus.cmd_a     = a;
      bus.cmd_b     = b;
      bus.cmd_c     = c;
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
      if (!op[3]) begin
         checkOutput("raw_alu_opc", {29'd0, bus.alu_opc}, {29'd0, op[2:0]});
      end

      lat = 1;
      while (!bus.res_valid && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
      checkOutput("latency", lat, exp_lat);
      checkOutput("res_data", {16'd0, bus.res_data}, {16'd0, exp_data});
      checkOutput("res_zer", {31'd0, bus.res_zer}, {31'd0, (exp_data == 16'h0000)});
      checkOutput("res_neg", {31'd0, bus.res_neg}, {31'd0, exp_data[15]});
      checkOutput("cmd_ready_done", {31'd0, bus.cmd_ready}, 32'd0);

      for (int i = 0; i < hold; i++) begin
         bus.cmd_valid = 1'($urandom_range(0, 1));
         bus.cmd_op    = 4'($urandom);
         bus.cmd_a     = 16'($urandom);
         @(posedge clk);
         #1;
         checkOutput("hold_valid", {31'd0, bus.res_valid}, 32'd1);
         checkOutput("hold_data", {16'd0, bus.res_data}, {16'd0, exp_data});
         checkOutput("hold_ready", {31'd0, bus.cmd_ready}, 32'd0);
      end

      bus.cmd_valid = 1'b0;
      bus.res_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.res_ready = 1'b0;
      checkOutput("post_valid", {31'd0, bus.res_valid}, 32'd0);
      checkOutput("post_ready", {31'd0, bus.cmd_ready}, 32'd1);

      if (lat >= 100) begin
         rst = 1'b1;
         @(posedge clk);
         #1;
         rst = 1'b0;
      end
   endtask

   // Main sequence: reset checks, the directed cases, random commands, and a
   // reset that aborts a multiply part-way through.
   initial begin
      int stray_valid;
      logic [3:0]  rop;
      logic [15:0] ra;
      logic [15:0] rb;

      num_vectors     = 0;
      num_miscompares = 0;
      rst             = 1'b1;
      bus.cmd_valid   = 1'b0;
      bus.cmd_op      = 4'h0;
      bus.cmd_a       = 16'h0000;
      bus.cmd_b       = 16'h0000;
      bus.cmd_c       = 1'b0;
      bus.res_ready   = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
      checkOutput("rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
      checkOutput("rst_res_data", {16'd0, bus.res_data}, 32'd0);
      checkOutput("rst_res_zer", {31'd0, bus.res_zer}, 32'd0);
      checkOutput("rst_res_neg", {31'd0, bus.res_neg}, 32'd0);
      checkOutput("rst_alu_m", {16'd0, bus.alu_m}, 32'd0);
      rst = 1'b0;
      #1;
      checkOutput("ready_after_rst", {31'd0, bus.cmd_ready}, 32'd1);

      applyStimulus(4'b0000, 16'h0005, 16'h0003, 1'b1, 0);
      applyStimulus(4'b1000, 16'h0003, 16'h0005, 1'b0, 0);
      applyStimulus(4'b1000, 16'h0007, 16'h0007, 1'b0, 0);
      applyStimulus(4'b1010, 16'hFFF6, 16'h0000, 1'b0, 0);
      applyStimulus(4'b1010, 16'h0004, 16'h0000, 1'b0, 0);
      applyStimulus(4'b1001, 16'h8000, 16'h0000, 1'b0, 0);
      applyStimulus(4'b1010, 16'h8000, 16'h0000, 1'b0, 0);
      applyStimulus(4'b1011, 16'hFFFD, 16'h0007, 1'b0, 5);
      applyStimulus(4'b1011, 16'h0100, 16'h0100, 1'b0, 0);
      applyStimulus(4'b1100, 16'h1234, 16'h5678, 1'b1, 2);
      applyStimulus(4'b0001, 16'h0010, 16'h8001, 1'b0, 0);

      for (int i = 0; i < 40; i++) begin
         rop = 4'($urandom);
         ra  = 16'($urandom);
         rb  = 16'($urandom);
         if ($urandom_range(0, 7) == 0) ra = 16'h8000;
         if ($urandom_range(0, 7) == 0) rb = 16'h0000;
         applyStimulus(rop, ra, rb, 1'($urandom), int'($urandom_range(0, 3)));
      end

      bus.cmd_valid = 1'b1;
      bus.cmd_op    = 4'b1011;
      bus.cmd_a     = 16'h1357;
      bus.cmd_b     = 16'h2468;
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
      repeat (19) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("abort_rst_ready", {31'd0, bus.cmd_ready}, 32'd0);
      checkOutput("abort_rst_valid", {31'd0, bus.res_valid}, 32'd0);
      rst = 1'b0;
      #1;
      checkOutput("abort_ready", {31'd0, bus.cmd_ready}, 32'd1);
      stray_valid = 0;
      for (int i = 0; i < 60; i++) begin
         @(posedge clk);
         #1;
         if (bus.res_valid) stray_valid++;
      end
      checkOutput("abort_no_result", stray_valid, 0);
      applyStimulus(4'b0101, 16'h00F0, 16'h0F0F, 1'b0, 1);

      $display("== %0d vectors applied, %0d miscompares ==", num_vectors, num_miscompares);
      $finish;
   end

endmodule
